// File: rtl/aes128_dec_key_sched.sv
// aes128_dec_key_sched: iterative AES-128 key expansion, one round per cycle, serving
// the 11 stored round keys in reverse order (optionally inv_mixcolumns'd for rounds 1..9).
`default_nettype none

module aes128_dec_key_sched #(
  parameter int EQUIV_INV = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         key_ready,
  input  logic         rk_rewind,
  output logic         rk_valid,
  input  logic         rk_ack,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_SERVE  = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // S-box packed big-endian: entry x lives at bits [(255-x)*8 +: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int j = 0; j < 4; j++) begin
      a[j]  = c[31-8*j -: 8];
      x2[j] = xtime(a[j]);
      x4[j] = xtime(x2[j]);
      x8[j] = xtime(x4[j]);
      m9[j] = x8[j] ^ a[j];
      mb[j] = x8[j] ^ x2[j] ^ a[j];
      md[j] = x8[j] ^ x4[j] ^ a[j];
      me[j] = x8[j] ^ x4[j] ^ x2[j];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] k);
    return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
            inv_mix_col(k[63:32]),  inv_mix_col(k[31:0])};
  endfunction

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [3:0]   r;
  logic [7:0]   rcon;
  logic         have_keys;
  logic [127:0] slot [0:10];

  logic         load_acc;
  logic         rewind_acc;
  logic         ack_acc;
  logic [127:0] prev_key;
  logic [31:0]  sub_rot;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic [127:0] next_key;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic [127:0] served_key;

  assign load_acc   = key_load && key_ready;
  // key_load only wins over rewind in HOLD; in SERVE key_ready is low so load_acc is 0.
  assign rewind_acc = rk_rewind && have_keys && !load_acc &&
                      ((state == S_SERVE) || (state == S_HOLD));
  assign ack_acc    = rk_valid && rk_ack && !rewind_acc;

  assign prev_key = slot[r - 4'd1];
  assign sub_rot  = {aes_sbox(prev_key[23:16]), aes_sbox(prev_key[15:8]),
                     aes_sbox(prev_key[7:0]),   aes_sbox(prev_key[31:24])} ^ {rcon, 24'h000000};
  assign nw0      = prev_key[127:96] ^ sub_rot;
  assign nw1      = prev_key[95:64]  ^ nw0;
  assign nw2      = prev_key[63:32]  ^ nw1;
  assign nw3      = prev_key[31:0]   ^ nw2;
  assign next_key = {nw0, nw1, nw2, nw3};

  assign rd_idx     = rk_idx - 4'd1;
  assign rd_key     = slot[rd_idx];
  assign served_key = ((EQUIV_INV != 0) && (rd_idx >= 4'd1) && (rd_idx <= 4'd9)) ?
                      inv_mix(rd_key) : rd_key;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (load_acc) state_nxt = S_EXPAND;
      S_EXPAND: if (r == LAST_ROUND) state_nxt = S_SERVE;
      S_SERVE:  if (!rewind_acc && ack_acc && (rk_idx == 4'd0)) state_nxt = S_HOLD;
      S_HOLD: begin
        if (load_acc)        state_nxt = S_EXPAND;
        else if (rewind_acc) state_nxt = S_SERVE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    key_ready = (state == S_IDLE) || (state == S_HOLD);
    busy      = (state == S_EXPAND);
    rk_valid  = (state == S_SERVE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r         <= 4'd0;
      rcon      <= 8'h00;
      have_keys <= 1'b0;
      rk_out    <= 128'd0;
      rk_idx    <= 4'd0;
    end else if (load_acc) begin
      r         <= 4'd1;
      rcon      <= 8'h01;
      have_keys <= 1'b0;
    end else if (state == S_EXPAND) begin
      r    <= r + 4'd1;
      rcon <= xtime(rcon);
      if (r == LAST_ROUND) begin
        rk_out    <= next_key;
        rk_idx    <= LAST_ROUND;
        have_keys <= 1'b1;
      end
    end else if (rewind_acc) begin
      rk_out <= slot[10];
      rk_idx <= LAST_ROUND;
    end else if (ack_acc && (rk_idx != 4'd0)) begin
      rk_out <= served_key;
      rk_idx <= rd_idx;
    end
  end

  // Round-key storage carries no reset; have_keys guards against stale contents.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (load_acc) begin
        slot[0] <= key_in;
      end else if (state == S_EXPAND) begin
        slot[r] <= next_key;
      end
    end
  end

endmodule

`default_nettype wire
